// File: rtl/gpio_blink_monitor_if.sv
// Signal bundle between a GPIO blink monitor and the bench or SoC harness that drives it.
// The harness owns enable and the pad level; the monitor reports blinks and its verdict.
interface gpio_blink_monitor_if;
  logic       enable;
  logic       gpio_in;
  logic       blink_strobe;
  logic [7:0] blink_count;
  logic       busy;
  logic       pass;
  logic       fail;
  logic [1:0] fail_code;

  modport master (
    output enable, gpio_in,
    input  blink_strobe, blink_count, busy, pass, fail, fail_code
  );

  modport slave (
    input  enable, gpio_in,
    output blink_strobe, blink_count, busy, pass, fail, fail_code
  );
endinterface

// File: rtl/gpio_blink_monitor.sv
// Watches the mgmt GPIO pad, debounces it, counts complete high-then-low blinks and
// reports pass after BLINK_TARGET blinks or fail if the pad stalls for TIMEOUT cycles.
module gpio_blink_monitor #(
  parameter int BLINK_TARGET = 10,
  parameter int MIN_PULSE    = 4,
  parameter int TIMEOUT      = 100000,
  parameter int CNT_W        = 20
) (
  input logic                 clock,
  input logic                 resetb,
  gpio_blink_monitor_if.slave mon
);

  localparam int FW = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
  localparam logic [FW-1:0]    FILT_LAST = FW'(MIN_PULSE - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       TARGET    = 8'(BLINK_TARGET);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT_LOW,
    ARMED,
    HIGH,
    DONE_PASS,
    DONE_FAIL
  } state_t;

  logic [1:0]       sync_reg;
  logic [FW-1:0]    filt_cnt_reg;
  logic             filt_reg;
  logic             filt_d_reg;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] tmo_reg, tmo_next;
  logic [7:0]       count_reg, count_next;
  logic             strobe_reg, strobe_next;
  logic [1:0]       code_reg, code_next;

  logic       sync_level;
  logic       rise_evt, fall_evt, edge_evt;
  logic       tmo_hit;
  logic       active;
  logic [7:0] count_inc;

  assign sync_level = sync_reg[1];

  // The filter holds its level until MIN_PULSE consecutive synced samples disagree with it.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync_reg     <= 2'b00;
      filt_cnt_reg <= '0;
      filt_reg     <= 1'b0;
      filt_d_reg   <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[0], mon.gpio_in};
      filt_d_reg <= filt_reg;
      if (sync_level == filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FILT_LAST) begin
        filt_reg     <= sync_level;
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + FW'(1);
      end
    end
  end

  assign rise_evt  = filt_reg & ~filt_d_reg;
  assign fall_evt  = ~filt_reg & filt_d_reg;
  assign edge_evt  = rise_evt | fall_evt;
  assign tmo_hit   = (tmo_reg == TMO_LAST);
  assign active    = (state_reg == WAIT_INIT_LOW) || (state_reg == ARMED) || (state_reg == HIGH);
  assign count_inc = (count_reg == 8'hFF) ? 8'hFF : count_reg + 8'd1;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_reg  <= IDLE;
      tmo_reg    <= '0;
      count_reg  <= 8'd0;
      strobe_reg <= 1'b0;
      code_reg   <= 2'b00;
    end else begin
      state_reg  <= state_next;
      tmo_reg    <= tmo_next;
      count_reg  <= count_next;
      strobe_reg <= strobe_next;
      code_reg   <= code_next;
    end
  end

  // A filtered edge always beats a coincident timeout; enable=0 beats everything.
  always_comb begin
    state_next  = state_reg;
    tmo_next    = tmo_reg;
    count_next  = count_reg;
    strobe_next = 1'b0;
    code_next   = code_reg;
    if (!mon.enable) begin
      state_next = IDLE;
      tmo_next   = '0;
      count_next = 8'd0;
      code_next  = 2'b00;
    end else begin
      case (state_reg)
        IDLE: state_next = WAIT_INIT_LOW;
        WAIT_INIT_LOW: begin
          if (!filt_reg) begin
            state_next = ARMED;
          end else if (tmo_hit && !edge_evt) begin
            state_next = DONE_FAIL;
            code_next  = 2'b10;
          end
        end
        ARMED: begin
          if (rise_evt) begin
            state_next = HIGH;
          end else if (tmo_hit && !edge_evt) begin
            state_next = DONE_FAIL;
            code_next  = 2'b01;
          end
        end
        HIGH: begin
          if (fall_evt) begin
            strobe_next = 1'b1;
            count_next  = count_inc;
            state_next  = (count_inc == TARGET) ? DONE_PASS : ARMED;
          end else if (tmo_hit && !edge_evt) begin
            state_next = DONE_FAIL;
            code_next  = 2'b10;
          end
        end
        default: ;
      endcase
      if ((state_next != state_reg) || edge_evt) begin
        tmo_next = '0;
      end else if (active) begin
        tmo_next = tmo_reg + CNT_W'(1);
      end
    end
  end

  assign mon.blink_strobe = strobe_reg;
  assign mon.blink_count  = count_reg;
  assign mon.busy         = active;
  assign mon.pass         = (state_reg == DONE_PASS);
  assign mon.fail         = (state_reg == DONE_FAIL);
  assign mon.fail_code    = code_reg;

endmodule

// File: tb/tb_gpio_blink_monitor.sv
// Bench for gpio_blink_monitor: directed scenarios plus random pad activity, every cycle
// checked against a behavioural model of the debounce and blink-counting rules.
module tb_gpio_blink_monitor;

  localparam int TARGET  = 10;
  localparam int MINP    = 4;
  localparam int TMO     = 400;
  localparam int CW      = 20;

  localparam int P_IDLE = 0, P_WAIT_LOW = 1, P_ARMED = 2, P_HIGH = 3, P_PASS = 4, P_FAIL = 5;

  logic clock = 1'b0;
  logic resetb;
  int   errors = 0;
  int   checks = 0;
  int   strobes_seen = 0;

  gpio_blink_monitor_if mon_if ();

  gpio_blink_monitor #(
    .BLINK_TARGET(TARGET),
    .MIN_PULSE   (MINP),
    .TIMEOUT     (TMO),
    .CNT_W       (CW)
  ) dut (
    .clock (clock),
    .resetb(resetb),
    .mon   (mon_if.slave)
  );

  always #5 clock = ~clock;

  // model state: pad delay line, recent synced samples, debounced level and monitor progress
  bit pipe_q[$];
  bit seen_q[$];
  bit f_m, f_lag_m;
  int m_phase, m_count, m_code, m_quiet;
  bit m_strobe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe_q = '{1'b0, 1'b0};
    seen_q = {};
    f_m = 1'b0; f_lag_m = 1'b0;
    m_phase = P_IDLE; m_count = 0; m_code = 0; m_quiet = 0; m_strobe = 1'b0;
  endtask

  task automatic model_edge();
    bit s_now, flip, rise, fall, edge_evt, stalled;
    int nxt;
    if (!resetb) begin
      model_reset();
      return;
    end
    s_now = pipe_q.pop_front();
    pipe_q.push_back(mon_if.gpio_in);
    rise = f_m && !f_lag_m;
    fall = !f_m && f_lag_m;
    edge_evt = rise || fall;
    stalled = (m_quiet == TMO - 1) && !edge_evt;
    m_strobe = 1'b0;
    if (!mon_if.enable) begin
      m_phase = P_IDLE; m_count = 0; m_code = 0; m_quiet = 0;
    end else begin
      nxt = m_phase;
      if (m_phase == P_IDLE) nxt = P_WAIT_LOW;
      else if (m_phase == P_WAIT_LOW) begin
        if (!f_m) nxt = P_ARMED;
        else if (stalled) begin nxt = P_FAIL; m_code = 2; end
      end else if (m_phase == P_ARMED) begin
        if (rise) nxt = P_HIGH;
        else if (stalled) begin nxt = P_FAIL; m_code = 1; end
      end else if (m_phase == P_HIGH) begin
        if (fall) begin
          m_strobe = 1'b1;
          m_count = (m_count >= 255) ? 255 : m_count + 1;
          nxt = (m_count == TARGET) ? P_PASS : P_ARMED;
        end else if (stalled) begin nxt = P_FAIL; m_code = 2; end
      end
      if (nxt != m_phase || edge_evt) m_quiet = 0;
      else if (m_phase >= P_WAIT_LOW && m_phase <= P_HIGH) m_quiet++;
      m_phase = nxt;
    end
    // debounced level changes once the last MINP synced samples all disagree with it
    seen_q.push_back(s_now);
    if (seen_q.size() > MINP) void'(seen_q.pop_front());
    flip = (seen_q.size() == MINP);
    foreach (seen_q[i]) if (seen_q[i] == f_m) flip = 1'b0;
    f_lag_m = f_m;
    if (flip) f_m = !f_m;
  endtask

  task automatic compare_all();
    chk("strobe", mon_if.blink_strobe, m_strobe);
    chk("count", mon_if.blink_count, m_count);
    chk("busy", mon_if.busy, (m_phase >= P_WAIT_LOW && m_phase <= P_HIGH));
    chk("pass", mon_if.pass, (m_phase == P_PASS));
    chk("fail", mon_if.fail, (m_phase == P_FAIL));
    chk("fail_code", mon_if.fail_code, m_code);
    chk("excl", mon_if.pass & mon_if.fail, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
    if (mon_if.blink_strobe === 1'b1) strobes_seen++;
    @(negedge clock);
  endtask

  task automatic hold(input bit lvl, input int n);
    mon_if.gpio_in = lvl;
    repeat (n) tick();
  endtask

  task automatic blinks(input int n, input int hi, input int lo);
    repeat (n) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  task automatic rearm();
    mon_if.enable = 1'b0;
    tick();
    mon_if.enable = 1'b1;
    strobes_seen = 0;
  endtask

  // ticks until pass (which=0) or fail (which=1) is seen, bounded by limit
  task automatic ticks_until(input int which, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if ((which == 0 && mon_if.pass === 1'b1) || (which == 1 && mon_if.fail === 1'b1)) return;
    end
    n = -1;
  endtask

  initial begin
    int n;
    bit lvl;
    resetb = 1'b0;
    mon_if.enable = 1'b0;
    mon_if.gpio_in = 1'b0;
    model_reset();
    repeat (3) tick();
    $display("reset: count=%0d busy=%0d pass=%0d", mon_if.blink_count, mon_if.busy, mon_if.pass);
    resetb = 1'b1;
    tick();

    // ten clean blinks, then measure latency from the final pad fall to pass
    mon_if.enable = 1'b1;
    hold(1'b0, 20);
    blinks(9, 50, 50);
    hold(1'b1, 50);
    mon_if.gpio_in = 1'b0;
    ticks_until(0, 60, n);
    chk("pass_lat", n, MINP + 3);
    chk("strobes10", strobes_seen, 10);
    chk("count10", mon_if.blink_count, 10);
    hold(1'b0, 40);
    blinks(2, 30, 30);
    chk("frozen", mon_if.blink_count, 10);
    $display("clean blinks: count=%0d pass=%0d strobes=%0d", mon_if.blink_count, mon_if.pass, strobes_seen);

    // one-cycle enable drop clears results and re-arms
    rearm();
    tick();
    chk("rearm_pass", mon_if.pass, 0);
    chk("rearm_count", mon_if.blink_count, 0);
    chk("rearm_busy", mon_if.busy, 1);
    $display("rearm: pass=%0d count=%0d busy=%0d", mon_if.pass, mon_if.blink_count, mon_if.busy);

    // short glitches are invisible; then the pad stays low until a stuck-low timeout
    repeat (5) begin
      hold(1'b1, MINP - 1);
      hold(1'b0, 50);
    end
    chk("glitch_strobes", strobes_seen, 0);
    chk("glitch_count", mon_if.blink_count, 0);
    ticks_until(1, TMO + 10, n);
    chk("stuck_low_seen", (n > 0), 1);
    chk("stuck_low_code", mon_if.fail_code, 1);
    $display("glitches: count=%0d fail=%0d code=%0d", mon_if.blink_count, mon_if.fail, mon_if.fail_code);

    // three blinks then the pad sticks high
    rearm();
    blinks(3, 50, 50);
    mon_if.gpio_in = 1'b1;
    ticks_until(1, TMO + 60, n);
    chk("stuck_high_lat", n, TMO + MINP + 3);
    chk("stuck_high_code", mon_if.fail_code, 2);
    chk("stuck_high_count", mon_if.blink_count, 3);
    $display("stuck high: count=%0d fail=%0d code=%0d", mon_if.blink_count, mon_if.fail, mon_if.fail_code);

    // pad already high when armed is not a blink
    mon_if.enable = 1'b0;
    hold(1'b1, 20);
    mon_if.enable = 1'b1;
    strobes_seen = 0;
    hold(1'b1, 100);
    hold(1'b0, 50);
    blinks(10, 40, 40);
    chk("init_high_count", mon_if.blink_count, 10);
    chk("init_high_pass", mon_if.pass, 1);
    $display("initial high: count=%0d pass=%0d", mon_if.blink_count, mon_if.pass);

    // asynchronous reset in the middle of a high phase
    rearm();
    blinks(5, 40, 40);
    hold(1'b1, 20);
    #2 resetb = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("async_count", mon_if.blink_count, 0);
    mon_if.gpio_in = 1'b0;
    repeat (3) tick();
    resetb = 1'b1;
    strobes_seen = 0;
    hold(1'b0, 20);
    blinks(10, 40, 40);
    chk("post_reset_count", mon_if.blink_count, 10);
    chk("post_reset_pass", mon_if.pass, 1);
    $display("reset mid-run: count=%0d pass=%0d", mon_if.blink_count, mon_if.pass);

    // random pad activity with occasional long stalls and enable drops
    lvl = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 14) == 0) rearm();
      lvl = !lvl;
      if ($urandom_range(0, 9) == 0) hold(lvl, $urandom_range(TMO - 20, TMO + 40));
      else hold(lvl, $urandom_range(1, 12));
    end
    $display("random: count=%0d pass=%0d fail=%0d", mon_if.blink_count, mon_if.pass, mon_if.fail);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
